iter_alu: RTL and testbench

- Parametrised, registered ALU for the RISC-V datapath.
- Executes the base 3-bit ALU operation set in one cycle. Adds iterative unsigned multiply and divide (shift-add / restoring), taking WIDTH cycles each.
- Valid/ready handshake on input and output, so the execute stage can stall on long operations.
- Result and the four status flags are registered and held until consumed.

---
 rtl/iter_alu.sv | 146 ++++++++++++++
 tb/tb_iter_alu.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Registered ALU: single-cycle base ops plus iterative unsigned multiply/divide,
// valid/ready on both sides, result and flags held until consumed.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             negative
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
        OP_EQ  = 4'd4, OP_NE  = 4'd5, OP_LTU = 4'd6, OP_GTU = 4'd7,
        OP_MUL = 4'd8, OP_MULHU = 4'd9, OP_DIVU = 4'd10, OP_REMU = 4'd11
    } op_t;

    state_t             state, state_nxt;
    op_t                op_e;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               accept, iter_op, is_sub;

    logic [WIDTH-1:0]   b_eff, basic_res, iter_res;
    logic [WIDTH:0]     sum;
    logic               basic_ov, basic_c;

    logic [WIDTH:0]     mul_add, div_tmp, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next;

    assign op_e      = op_t'(op);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign iter_op   = op[3] && !op[2];
    assign is_sub    = (op_e == OP_SUB);

    always_comb begin
        b_eff     = is_sub ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
        basic_res = '0;
        basic_ov  = 1'b0;
        basic_c   = 1'b0;
        case (op_e)
            OP_ADD, OP_SUB: begin
                basic_res = sum[WIDTH-1:0];
                basic_c   = sum[WIDTH];
                // SUB sees ~b, so one same-sign test covers both directions
                basic_ov  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  basic_res = a & b;
            OP_OR:   basic_res = a | b;
            OP_EQ:   basic_res = {{(WIDTH-1){1'b0}}, a == b};
            OP_NE:   basic_res = {{(WIDTH-1){1'b0}}, a != b};
            OP_LTU:  basic_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_GTU:  basic_res = {{(WIDTH-1){1'b0}}, a > b};
            default: basic_res = '0;
        endcase
    end

    // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
    // Divide:   acc = {partial remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        mul_add  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_add, acc[WIDTH-1:1]};
        div_tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = (div_tmp >= {1'b0, b_q});
        div_diff = div_tmp - {1'b0, b_q};
        div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end

    assign iter_res = op_q[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = iter_op ? BUSY : DONE;
            BUSY:    if (cnt == CW'(WIDTH)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (accept) begin
            op_q <= op[1:0];
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
            if (iter_op) begin
                acc <= op[1] ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            end else begin
                result   <= basic_res;
                overflow <= basic_ov;
                carry    <= basic_c;
                zero     <= (basic_res == '0);
                negative <= basic_res[WIDTH-1];
            end
        end else if (state == BUSY) begin
            if (cnt != CW'(WIDTH)) begin
                acc <= op_q[1] ? div_next : mul_next;
                cnt <= cnt + CW'(1);
            end else begin
                result   <= iter_res;
                overflow <= 1'b0;
                carry    <= 1'b0;
                zero     <= (iter_res == '0);
                negative <= iter_res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: a 32-bit and an 8-bit instance share clock and reset.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid32 = 1'b0, out_ready32 = 1'b0;
    logic [3:0]  op32 = '0;
    logic [31:0] opa32 = '0, opb32 = '0;
    logic        in_ready32, out_valid32, ovf32, carry32, zero32, neg32;
    logic [31:0] result32;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  opa8 = '0, opb8 = '0;
    logic        in_ready8, out_valid8, ovf8, carry8, zero8, neg8;
    logic [7:0]  result8;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          w;
        string       name;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(32), .OPW(4)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op32), .a(opa32), .b(opb32), .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .overflow(ovf32), .carry(carry32), .zero(zero32), .negative(neg32)
    );

    iter_alu #(.WIDTH(8), .OPW(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(opa8), .b(opb8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .overflow(ovf8), .carry(carry8), .zero(zero8), .negative(neg8)
    );

    task automatic drive(input int w, input logic v, input logic [3:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        if (w == 32) begin
            in_valid32 = v; op32 = o; opa32 = x; opb32 = y;
        end else begin
            in_valid8 = v; op8 = o; opa8 = x[7:0]; opb8 = y[7:0];
        end
    endtask

    task automatic set_ready(input int w, input logic r);
        if (w == 32) out_ready32 = r;
        else         out_ready8  = r;
    endtask

    // flags packed as {overflow, carry, zero, negative}
    task automatic sample(input int w, output logic irdy, output logic ovld,
                          output logic [31:0] res, output logic [3:0] flags);
        if (w == 32) begin
            irdy = in_ready32; ovld = out_valid32; res = result32;
            flags = {ovf32, carry32, zero32, neg32};
        end else begin
            irdy = in_ready8; ovld = out_valid8; res = {24'h0, result8};
            flags = {ovf8, carry8, zero8, neg8};
        end
    endtask

    task automatic issue(input int w, input string name, input logic [3:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic eov, input logic ec);
        exp_t e;
        logic irdy, ovld;
        logic [31:0] r;
        logic [3:0] f;
        @(negedge clk);
        sample(w, irdy, ovld, r, f);
        vectors++;
        if (irdy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s in_ready before issue: got %b want 1", name, irdy);
        end
        drive(w, 1'b1, o, x, y);
        @(posedge clk);
        #1 drive(w, 1'b0, 4'd0, 32'd0, 32'd0);
        e.w     = w;
        e.name  = name;
        e.res   = er;
        e.flags = {eov, ec, (er == 32'd0), (w == 32) ? er[31] : er[7]};
        e.lat   = (o >= 4'd8 && o <= 4'd11) ? w + 1 : 1;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        int lat;
        logic got, irdy, ovld;
        logic [31:0] r;
        logic [3:0] f;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL drain: scoreboard empty, got 0 entries want >=1");
            return;
        end
        e = sb.pop_front();
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            sample(e.w, irdy, ovld, r, f);
            got = ovld;
        end
        if (!got) begin
            miscompares++;
            $display("FAIL %s out_valid timeout: got none after %0d cycles want %0d", e.name, lat, e.lat);
            return;
        end
        vectors++;
        if (lat != e.lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat);
        end
        vectors++;
        if (r !== e.res) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h", e.name, r, e.res);
        end
        vectors++;
        if (f !== e.flags) begin
            miscompares++;
            $display("FAIL %s flags(ov,c,z,n): got %b want %b", e.name, f, e.flags);
        end
        set_ready(e.w, 1'b1);
        @(posedge clk);
        #1 set_ready(e.w, 1'b0);
        @(negedge clk);
        sample(e.w, irdy, ovld, r, f);
        vectors++;
        if (irdy !== 1'b1 || ovld !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after consume in_ready/out_valid: got %b%b want 10", e.name, irdy, ovld);
        end
    endtask

    task automatic test_reset();
        logic irdy, ovld;
        logic [31:0] r;
        logic [3:0] f;
        #12;
        for (int w = 8; w <= 32; w += 24) begin
            sample(w, irdy, ovld, r, f);
            vectors++;
            if ({irdy, ovld} !== 2'b10) begin
                miscompares++;
                $display("FAIL reset%0d in_ready/out_valid: got %b%b want 10", w, irdy, ovld);
            end
            vectors++;
            if (r !== 32'd0 || f !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset%0d result/flags: got %h/%b want 0/0000", w, r, f);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_mul();
        logic irdy, ovld;
        logic [31:0] r;
        logic [3:0] f;
        issue(32, "mul_reset", 4'd8, 32'd7, 32'd9, 32'd63, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 sample(32, irdy, ovld, r, f);
        sb.delete();
        vectors++;
        if ({irdy, ovld} !== 2'b10 || r !== 32'd0 || f !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_mul_reset outputs: got rdy=%b vld=%b res=%h flags=%b want 1 0 0 0000",
                     irdy, ovld, r, f);
        end
        @(negedge clk);
        rst = 1'b1;
        issue(32, "add_after_reset", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_basic_ops();
        issue(32, "add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0);
        drain();
        issue(32, "sub_eq", 4'd1, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
        drain();
        issue(32, "sub_neg", 4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0);
        drain();
        issue(32, "sub_ovf", 4'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b1);
        drain();
        issue(32, "or", 4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0);
        drain();
        issue(32, "eq", 4'd4, 32'd5, 32'd5, 32'd1, 1'b0, 1'b0);
        drain();
        issue(32, "ne", 4'd5, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
        drain();
        issue(32, "reserved", 4'd12, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_mul();
        issue(32, "mul", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        drain();
        issue(32, "mulhu", 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        drain();
        issue(32, "mul_small", 4'd8, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_div();
        issue(32, "divu", 4'd10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        drain();
        issue(32, "remu", 4'd11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
        drain();
        issue(32, "divu_by0", 4'd10, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        drain();
        issue(32, "remu_by0", 4'd11, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0);
        drain();
        issue(32, "divu_big", 4'd10, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_backpressure();
        logic irdy, ovld;
        logic [31:0] r;
        logic [3:0] f;
        issue(32, "and_hold", 4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(32, 1'b1, 4'd0, 32'd1, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sample(32, irdy, ovld, r, f);
            vectors++;
            if (r !== 32'h00F000F0 || ovld !== 1'b1 || irdy !== 1'b0) begin
                miscompares++;
                $display("FAIL hold cycle %0d: got res=%h vld=%b rdy=%b want 00f000f0 1 0", i, r, ovld, irdy);
            end
        end
        drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
        drain();
    endtask

    task automatic test_back_to_back();
        issue(32, "b2b_add", 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1);
        drain();
        issue(32, "b2b_mul", 4'd8, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
        drain();
        issue(32, "b2b_and", 4'd2, 32'hFFFF0000, 32'h12345678, 32'h12340000, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_width8();
        issue(8, "ltu8", 4'd6, 32'h01, 32'hFF, 32'h01, 1'b0, 1'b0);
        drain();
        issue(8, "gtu8", 4'd7, 32'h01, 32'hFF, 32'h00, 1'b0, 1'b0);
        drain();
        issue(8, "mul8", 4'd8, 32'd15, 32'd17, 32'hFF, 1'b0, 1'b0);
        drain();
        issue(8, "divu8", 4'd10, 32'hFF, 32'h10, 32'h0F, 1'b0, 1'b0);
        drain();
        issue(8, "add8_ovf", 4'd0, 32'h7F, 32'h01, 32'h80, 1'b1, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid_mul();
        test_basic_ops();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
